// File: rtl/dpram_arb_pkg.sv
// Shared defaults and port identifiers for the dual-port RAM access arbiter.
package dpram_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int N_REQ_DEF  = 4;
  localparam int CNT_W      = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

endpackage

// File: rtl/dpram_rr_pick.sv
// Rotating first-set finder: returns the first asserted request at or after ptr,
// wrapping around N entries.
module dpram_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dpram_access_arbiter.sv
// Arbitrates N_REQ requesters onto the two ports of a dual-port RAM with
// rotating priority, same-address write hazard stalls and 1-cycle read return.
module dpram_access_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_REQ  = N_REQ_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [N_REQ*DATA_W-1:0]  rsp_data,
  output logic                     ram_we_a,
  output logic                     ram_re_a,
  output logic [ADDR_W-1:0]        ram_addr_a,
  output logic [DATA_W-1:0]        ram_din_a,
  input  logic [DATA_W-1:0]        ram_dout_a,
  output logic                     ram_we_b,
  output logic                     ram_re_b,
  output logic [ADDR_W-1:0]        ram_addr_b,
  output logic [DATA_W-1:0]        ram_din_b,
  input  logic [DATA_W-1:0]        ram_dout_b,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        conflict_cnt_q, conflict_cnt_d;
  logic [1:0]              pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]        pend_owner_q [2];
  logic [IDX_W-1:0]        pend_owner_d [2];
  logic [N_REQ*DATA_W-1:0] rsp_hold_q, rsp_hold_d;

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  logic [N_REQ-1:0] valid_g;
  logic [N_REQ-1:0] conflict_mask;
  logic [N_REQ-1:0] mask_b;
  logic             found_a, found_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic [ADDR_W-1:0] addr_a;
  logic             we_a, we_b;
  logic             stall;

  function automatic int rot_dist(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] p);
    int d;
    d = int'(i) - int'(p);
    if (d < 0) begin
      d = d + N_REQ;
    end
    return d;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Reset gates every request so nothing reaches the RAM while rst is low.
  assign valid_g = rst ? req_valid : '0;

  dpram_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick_a (
    .req   (valid_g),
    .ptr   (rr_ptr_q),
    .found (found_a),
    .idx   (idx_a)
  );

  always_comb begin
    addr_a        = addr_arr[idx_a];
    we_a          = found_a & req_we[idx_a];
    conflict_mask = '0;
    mask_b        = valid_g;
    if (found_a) begin
      mask_b[idx_a] = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if ((i != int'(idx_a)) && valid_g[i] && (addr_arr[i] == addr_a) &&
            (req_we[i] || we_a)) begin
          conflict_mask[i] = 1'b1;
        end
      end
    end
    mask_b = mask_b & ~conflict_mask;
  end

  dpram_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick_b (
    .req   (mask_b),
    .ptr   (rr_ptr_q),
    .found (found_b),
    .idx   (idx_b)
  );

  assign we_b = found_b & req_we[idx_b];

  // A stall counts when a conflicting requester sat ahead of the eventual port-B winner.
  always_comb begin
    int dist_b;
    stall  = 1'b0;
    dist_b = found_b ? rot_dist(idx_b, rr_ptr_q) : N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (conflict_mask[i] && (rot_dist(IDX_W'(i), rr_ptr_q) < dist_b)) begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    ram_we_a   = 1'b0;
    ram_re_a   = 1'b0;
    ram_addr_a = '0;
    ram_din_a  = '0;
    ram_we_b   = 1'b0;
    ram_re_b   = 1'b0;
    ram_addr_b = '0;
    ram_din_b  = '0;
    if (found_a) begin
      req_ready[idx_a] = 1'b1;
      ram_we_a         = we_a;
      ram_re_a         = ~we_a;
      ram_addr_a       = addr_a;
      ram_din_a        = we_a ? wdata_arr[idx_a] : '0;
    end
    if (found_b) begin
      req_ready[idx_b] = 1'b1;
      ram_we_b         = we_b;
      ram_re_b         = ~we_b;
      ram_addr_b       = addr_arr[idx_b];
      ram_din_b        = we_b ? wdata_arr[idx_b] : '0;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found_b) begin
      rr_ptr_d = next_idx(idx_b);
    end else if (found_a) begin
      rr_ptr_d = next_idx(idx_a);
    end

    conflict_cnt_d = conflict_cnt_q;
    if (stall && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end

    pend_valid_d[PORT_A] = found_a & ~we_a;
    pend_valid_d[PORT_B] = found_b & ~we_b;
    pend_owner_d[PORT_A] = idx_a;
    pend_owner_d[PORT_B] = idx_b;
  end

  // Read data flows straight from the RAM in the return cycle, then is held.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = rsp_hold_q;
    if (pend_valid_q[PORT_A]) begin
      rsp_valid[pend_owner_q[PORT_A]] = 1'b1;
      rsp_data[int'(pend_owner_q[PORT_A])*DATA_W +: DATA_W] = ram_dout_a;
    end
    if (pend_valid_q[PORT_B]) begin
      rsp_valid[pend_owner_q[PORT_B]] = 1'b1;
      rsp_data[int'(pend_owner_q[PORT_B])*DATA_W +: DATA_W] = ram_dout_b;
    end
  end

  assign rsp_hold_d   = rsp_data;
  assign conflict_cnt = conflict_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q             <= '0;
      conflict_cnt_q       <= '0;
      pend_valid_q         <= '0;
      pend_owner_q[PORT_A] <= '0;
      pend_owner_q[PORT_B] <= '0;
      rsp_hold_q           <= '0;
    end else begin
      rr_ptr_q             <= rr_ptr_d;
      conflict_cnt_q       <= conflict_cnt_d;
      pend_valid_q         <= pend_valid_d;
      pend_owner_q[PORT_A] <= pend_owner_d[PORT_A];
      pend_owner_q[PORT_B] <= pend_owner_d[PORT_B];
      rsp_hold_q           <= rsp_hold_d;
    end
  end

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// Self-checking bench for dpram_access_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural arbiter/RAM model.
module tb_dpram_access_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 4;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] rsp_valid;
  logic [NR*DW-1:0] rsp_data;
  logic          ram_we_a, ram_re_a, ram_we_b, ram_re_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic [15:0]   conflict_cnt;

  int checks;
  int failures;

  dpram_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_REQ(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .ram_we_a     (ram_we_a),
    .ram_re_a     (ram_re_a),
    .ram_addr_a   (ram_addr_a),
    .ram_din_a    (ram_din_a),
    .ram_dout_a   (ram_dout_a),
    .ram_we_b     (ram_we_b),
    .ram_re_b     (ram_re_b),
    .ram_addr_b   (ram_addr_b),
    .ram_din_b    (ram_din_b),
    .ram_dout_b   (ram_dout_b),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External dual-port RAM, read-before-write, one-cycle read latency.
  logic [DW-1:0] mem [1 << AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ram_dout_a = '0;
    ram_dout_b = '0;
  end
  always @(posedge clk) begin
    if (ram_re_a) ram_dout_a <= mem[ram_addr_a];
    if (ram_re_b) ram_dout_b <= mem[ram_addr_b];
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  int            m_ptr;
  int            m_cnt;
  logic [NR-1:0] m_rsp_valid;
  logic [DW-1:0] m_rsp_data [NR];
  logic [DW-1:0] shadow [1 << AW];
  int            ga, gb;
  bit            stalled;
  logic [NR-1:0] e_ready;

  function automatic logic [AW-1:0] f_addr(int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] f_wdata(int i);
    return req_wdata[i*DW +: DW];
  endfunction

  task automatic model_reset();
    m_ptr       = 0;
    m_cnt       = 0;
    m_rsp_valid = '0;
    for (int i = 0; i < NR; i++) m_rsp_data[i] = '0;
  endtask

  // Scan requesters from the pointer: first valid goes to A, the next
  // non-hazardous one goes to B; hazards met before B is chosen are stalls.
  task automatic model_comb();
    ga = -1;
    gb = -1;
    stalled = 0;
    e_ready = '0;
    if (rst) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (req_valid[i]) begin
          if (ga < 0) begin
            ga = i;
          end else if (gb < 0) begin
            if ((f_addr(i) == f_addr(ga)) && (req_we[i] || req_we[ga])) stalled = 1;
            else gb = i;
          end
        end
      end
    end
    if (ga >= 0) e_ready[ga] = 1'b1;
    if (gb >= 0) e_ready[gb] = 1'b1;
  endtask

  task automatic model_clock();
    logic [NR-1:0] nv;
    nv = '0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (ga >= 0 && !req_we[ga]) begin nv[ga] = 1'b1; m_rsp_data[ga] = shadow[f_addr(ga)]; end
    if (gb >= 0 && !req_we[gb]) begin nv[gb] = 1'b1; m_rsp_data[gb] = shadow[f_addr(gb)]; end
    if (ga >= 0 && req_we[ga]) shadow[f_addr(ga)] = f_wdata(ga);
    if (gb >= 0 && req_we[gb]) shadow[f_addr(gb)] = f_wdata(gb);
    if (gb >= 0) m_ptr = (gb + 1) % NR;
    else if (ga >= 0) m_ptr = (ga + 1) % NR;
    if (stalled && m_cnt < 65535) m_cnt++;
    m_rsp_valid = nv;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [NR*DW-1:0] e_data;
    for (int i = 0; i < NR; i++) e_data[i*DW +: DW] = m_rsp_data[i];
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("ram_we_a", 32'(ram_we_a), 32'(ga >= 0 && req_we[ga]));
    check("ram_re_a", 32'(ram_re_a), 32'(ga >= 0 && !req_we[ga]));
    check("ram_addr_a", 32'(ram_addr_a), (ga >= 0) ? 32'(f_addr(ga)) : 32'd0);
    if (ga >= 0 && req_we[ga]) check("ram_din_a", 32'(ram_din_a), 32'(f_wdata(ga)));
    if (ga < 0) check("ram_din_a_idle", 32'(ram_din_a), 32'd0);
    check("ram_we_b", 32'(ram_we_b), 32'(gb >= 0 && req_we[gb]));
    check("ram_re_b", 32'(ram_re_b), 32'(gb >= 0 && !req_we[gb]));
    check("ram_addr_b", 32'(ram_addr_b), (gb >= 0) ? 32'(f_addr(gb)) : 32'd0);
    if (gb >= 0 && req_we[gb]) check("ram_din_b", 32'(ram_din_b), 32'(f_wdata(gb)));
    if (gb < 0) check("ram_din_b_idle", 32'(ram_din_b), 32'd0);
    check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    check("rsp_data", 32'(rsp_data), 32'(e_data));
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
  endtask

  // Called at a falling edge; inputs settle for 1 time unit before checks.
  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR-1:0] w,
                               input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d);
    req_valid = v;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
    #1;
    model_comb();
  endtask

  task automatic step();
    model_comb();
    checkOutput();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic resetCycle(input logic [NR-1:0] v);
    rst = 1'b0;
    applyStimulus(v, '0, '0, '0);
    model_reset();
    step();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int cnt_before;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
    model_reset();
    ga = -1;
    gb = -1;
    stalled = 0;
    e_ready = '0;
    @(negedge clk);
    $display("[TB] start");

    // Reset then idle
    resetCycle('0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus('0, '0, '0, '0);
      check("idle_ready", 32'(req_ready), 32'd0);
      check("idle_strobes", 32'({ram_we_a, ram_re_a, ram_we_b, ram_re_b}), 32'd0);
      step();
    end

    // All four read continuously: pairs {0,1},{2,3}
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b1111, 4'b0000, 16'h3210, '0);
      check("pair_ready", 32'(req_ready), (c % 2 == 0) ? 32'h3 : 32'hC);
      step();
    end

    // Requester 0 writes A5 to addr 3, then requester 2 reads it back
    applyStimulus(4'b0001, 4'b0001, 16'h0003, 32'h0000_00A5);
    check("wr_ready", 32'(req_ready), 32'h1);
    step();
    applyStimulus(4'b0100, 4'b0000, 16'h0300, '0);
    check("rd_ready", 32'(req_ready), 32'h4);
    step();
    applyStimulus('0, '0, '0, '0);
    check("rd_rsp_valid", 32'(rsp_valid), 32'h4);
    check("rd_rsp_data", 32'(rsp_data[23:16]), 32'hA5);
    step();
    applyStimulus('0, '0, '0, '0);
    check("rd_rsp_hold", 32'(rsp_data[23:16]), 32'hA5);
    check("rd_rsp_pulse", 32'(rsp_valid), 32'h0);
    step();

    // Write/read hazard on addr 5
    cnt_before = m_cnt;
    applyStimulus(4'b0011, 4'b0001, 16'h0055, 32'h0000_003C);
    check("haz_ready", 32'(req_ready), 32'h1);
    step();
    check("haz_cnt", 32'(conflict_cnt), 32'(cnt_before + 1));
    applyStimulus(4'b0010, 4'b0000, 16'h0050, '0);
    check("haz_retry_ready", 32'(req_ready), 32'h2);
    step();
    applyStimulus('0, '0, '0, '0);
    check("haz_rsp_valid", 32'(rsp_valid), 32'h2);
    check("haz_rsp_data", 32'(rsp_data[15:8]), 32'h3C);
    step();

    // Two reads of addr 7 share the cycle without a stall
    cnt_before = m_cnt;
    applyStimulus(4'b1010, 4'b0000, 16'h7070, '0);
    check("dual_rd_ready", 32'(req_ready), 32'hA);
    step();
    applyStimulus('0, '0, '0, '0);
    check("dual_rsp_valid", 32'(rsp_valid), 32'hA);
    check("dual_rsp_same", 32'(rsp_data[31:24]), 32'(rsp_data[15:8]) ^ 32'(shadow[7]) ^ 32'(m_rsp_data[3]));
    check("dual_cnt", 32'(conflict_cnt), 32'(cnt_before));
    step();

    // Read accepted, then reset for one cycle: the response is dropped
    applyStimulus(4'b0001, 4'b0000, 16'h0000, '0);
    step();
    resetCycle(4'b1111);
    applyStimulus('0, '0, '0, '0);
    check("post_rst_rsp", 32'(rsp_valid), 32'h0);
    check("post_rst_cnt", 32'(conflict_cnt), 32'h0);
    step();
    applyStimulus(4'b1111, 4'b0000, 16'h3210, '0);
    check("post_rst_ptr", 32'(req_ready), 32'h3);
    step();

    // Randomized traffic; a stalled requester holds its request
    for (int c = 0; c < 400; c++) begin
      logic [NR-1:0]    v, w;
      logic [NR*AW-1:0] a;
      logic [NR*DW-1:0] d;
      v = req_valid;
      w = req_we;
      a = req_addr;
      d = req_wdata;
      for (int i = 0; i < NR; i++) begin
        if (!(req_valid[i] && !e_ready[i])) begin
          v[i]           = ($urandom_range(0, 9) < 7);
          w[i]           = $urandom_range(0, 1);
          a[i*AW +: AW]  = AW'($urandom_range(0, 3));
          d[i*DW +: DW]  = DW'($urandom);
        end
      end
      if (c == 200) begin
        resetCycle(v);
      end
      applyStimulus(v, w, a, d);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_access_arbiter.md
DPRAM_ACCESS_ARBITER -- requirements
Module: dpram_access_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-002 SHALL have parameter ADDR_W, default 4, RAM address width.
REQ-003 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-004 SHALL have clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have req_valid, input, N_REQ, per-requester request valid.
REQ-007 SHALL have req_we, input, N_REQ, per-requester write (1) / read (0).
REQ-008 SHALL have req_addr, input, N_REQ*ADDR_W, per-requester address, requester i in slice i.
REQ-009 SHALL have req_wdata, input, N_REQ*DATA_W, per-requester write data.
REQ-010 SHALL have req_ready, output, N_REQ, grant; transfer occurs when valid and ready are both high.
REQ-011 SHALL have rsp_valid, output, N_REQ, read data valid pulse.
REQ-012 SHALL have rsp_data, output, N_REQ*DATA_W, per-requester read data.
REQ-013 SHALL have ram_we_a, ram_re_a, ram_addr_a, ram_din_a as outputs, and ram_dout_a (DATA_W) as input, for RAM port A.
REQ-014 SHALL have ram_we_b, ram_re_b, ram_addr_b, ram_din_b as outputs, and ram_dout_b as input, for RAM port B, with the same widths as port A.
REQ-015 SHALL have conflict_cnt, output, 16, saturating count of address-conflict stall cycles.

Function
REQ-016 SHALL, each cycle, scan requesters in rotating priority order starting at rr_ptr and grant the first valid requester to port A.
REQ-017 SHALL grant the next valid requester in the same order to port B, except when that requester's address equals port A's address and either request is a write; in that case it SHALL be stalled and the scan SHALL continue.
REQ-018 SHALL grant at most 2 requesters per cycle, at most one per port.
REQ-019 SHALL drive req_ready and all ram_* control outputs combinationally from the current cycle's grant; the RAM samples them on the next edge.
REQ-020 SHALL assert ram_we_x for a granted write and ram_re_x for a granted read, never both; an idle port SHALL drive we=0, re=0, addr=0, din=0.
REQ-021 SHALL advance rr_ptr to (last granted index + 1) mod N_REQ; rr_ptr SHALL hold when no grant occurs.
REQ-022 SHALL register the owner index and port of each accepted read; one cycle later it SHALL pulse rsp_valid[owner] for one cycle, with rsp_data[owner] equal to ram_dout of that port (read latency 1).
REQ-023 SHALL hold rsp_data slices at their previous value when rsp_valid is low.
REQ-024 SHALL make a write accepted in cycle t visible to any read accepted in cycle t+1 or later.
REQ-025 SHALL increment conflict_cnt in each cycle in which a REQ-017 stall removes a grant that would otherwise occur; conflict_cnt SHALL saturate at 0xFFFF.
REQ-026 SHALL not depend on requester behaviour after a stall: a stalled requester SHALL hold its request stable while valid=1 and ready=0, and SHALL be re-evaluated the next cycle.

Reset
REQ-027 SHALL, while rst=0, force req_ready=0, rsp_valid=0, rsp_data=0, all ram_* outputs=0, rr_ptr=0, conflict_cnt=0, and clear pending-read tracking.
REQ-028 SHALL discard a read accepted in the cycle before a reset assertion; no rsp_valid pulse SHALL follow reset release.
REQ-029 SHALL not reset RAM contents, which are outside this block.

Structure
REQ-030 SHALL place the default widths, N_REQ, and the port-id enumeration (PORT_A, PORT_B) in the shared package dpram_arb_pkg.
REQ-031 SHALL implement the rotating first-set finder as sub-module dpram_rr_pick, instantiated twice: once for port A, and once with the port-A winner and conflicting requesters masked.

Verification
REQ-032 Reset then idle: after release, all outputs = 0; req_valid=0 -> no ram strobes, conflict_cnt stays 0.
REQ-033 Requester 0 writes 0xA5 to address 3; next cycle requester 2 reads address 3 -> rsp_valid[2] one cycle later with rsp_data[2]=0xA5.
REQ-034 All 4 requesters issue reads continuously -> grants in pairs {0,1},{2,3},{0,1}...; each requester is granted every 2 cycles.
REQ-035 Requester 0 writes address 5 while requester 1 reads address 5 in the same cycle -> only requester 0 granted; conflict_cnt becomes 1; requester 1 granted next cycle and reads the new data.
REQ-036 Requesters 1 and 3 both read address 7 in the same cycle -> both granted (ports A and B); both receive identical data; conflict_cnt unchanged.
REQ-037 Read accepted, then rst asserted for 1 cycle -> no rsp_valid after release; rr_ptr restarts at 0.
